// File: rtl/lsu_pmp_gate.sv
// lsu_pmp_gate: single-outstanding LSU request gate doing alignment and PMP checks
// before the data bus, and returning precise faults with cause and tval.
module lsu_pmp_gate #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr,
  input  logic [1:0]              req_size,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic                    flush,
  output logic [ADDR_WIDTH-1:0]   pmp_chk_addr,
  output logic [1:0]              pmp_chk_mode,
  input  logic                    pmp_pass,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  output logic                    bus_req_wr,
  output logic [DATA_WIDTH-1:0]   bus_req_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_req_strb,
  input  logic                    bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata,
  input  logic                    bus_rsp_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_fault,
  output logic [3:0]              rsp_cause,
  output logic [ADDR_WIDTH-1:0]   rsp_tval
);
  typedef enum logic [2:0] {IDLE, CHECK, BUS_REQ, BUS_WAIT, RESP} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    fault_q, fault_d;
  logic [3:0]              cause_q, cause_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    drop_q, drop_d;
  logic                    misal, chk_en;
  // size 3 is decoded as word by testing size[1]
  assign misal  = (size_q == 2'd1 && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00);
  assign chk_en = state_q == CHECK && !misal;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    fault_d = fault_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wr_d    = req_wr;
        size_d  = req_size;
        wdata_d = req_wdata;
        strb_d  = req_strb;
        fault_d = 1'b0;
        cause_d = 4'd0;
        rdata_d = '0;
        drop_d  = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = flush ? IDLE : misal || !pmp_pass ? RESP : BUS_REQ;
        fault_d = !flush && (misal || !pmp_pass);
        cause_d = fault_d ? {2'b01, wr_q, !misal} : 4'd0;
      end
      BUS_REQ: begin
        drop_d  = drop_q || flush;
        state_d = bus_req_ready ? BUS_WAIT : BUS_REQ;
      end
      BUS_WAIT: begin
        drop_d = drop_q || flush;
        if (bus_rsp_valid) begin
          state_d = drop_d ? IDLE : RESP;
          rdata_d = wr_q || bus_rsp_err ? '0 : bus_rsp_rdata;
          fault_d = bus_rsp_err;
          cause_d = bus_rsp_err ? {2'b01, wr_q, 1'b1} : 4'd0;
        end
      end
      RESP: state_d = flush || rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      strb_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= 4'd0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end
  assign req_ready     = state_q == IDLE;
  assign pmp_chk_addr  = chk_en ? addr_q : '0;
  assign pmp_chk_mode  = chk_en ? (wr_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus_req_valid = state_q == BUS_REQ;
  assign bus_req_addr  = addr_q;
  assign bus_req_wr    = wr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_strb  = strb_q;
  assign rsp_valid     = state_q == RESP;
  assign rsp_rdata     = rdata_q;
  assign rsp_fault     = fault_q;
  assign rsp_cause     = cause_q;
  assign rsp_tval      = fault_q ? addr_q : '0;
endmodule
